// File: rtl/maxnet_winner_detect.sv
// Maxnet resolution monitor: watches one activation vector per accepted beat.
// Reports a stable single survivor, an all-dead field, or an exhausted iteration budget.
module maxnet_winner_detect #(
  parameter int N        = 4,
  parameter int DATA_W   = 32,
  parameter int MAX_ITER = 64,
  parameter int STABLE   = 1,
  localparam int IDX_W   = $clog2(N),
  localparam int CNT_W   = $clog2(MAX_ITER + 1),
  localparam int NZ_W    = $clog2(N + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                ack,
  input  logic                in_valid,
  input  logic [N*DATA_W-1:0] x,
  input  logic [N*DATA_W-1:0] a,
  output logic                in_ready,
  output logic                done,
  output logic [1:0]          status,
  output logic [IDX_W-1:0]    win_idx,
  output logic [DATA_W-1:0]   win_value,
  output logic [CNT_W-1:0]    iter_count,
  output logic [NZ_W-1:0]     nz_count
);

  localparam int ST_W = $clog2(STABLE + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;
  typedef enum logic [1:0] {NONE_YET, WIN, ALL_ZERO, TIMEOUT} status_t;

  state_t              state_q, state_d;
  status_t             status_q, status_d;
  logic [IDX_W-1:0]    win_idx_q, win_idx_d;
  logic [DATA_W-1:0]   win_value_q, win_value_d;
  logic [CNT_W-1:0]    iter_q, iter_d, iter_inc;
  logic [NZ_W-1:0]     nz_q, nz_d, nz_cnt;
  logic [ST_W-1:0]     stable_q, stable_d, stable_nx;
  logic                found;
  logic [IDX_W-1:0]    sel_idx;
  logic [DATA_W-1:0]   sel_val;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      status_q    <= NONE_YET;
      win_idx_q   <= '0;
      win_value_q <= '0;
      iter_q      <= '0;
      nz_q        <= '0;
      stable_q    <= '0;
    end else begin
      state_q     <= state_d;
      status_q    <= status_d;
      win_idx_q   <= win_idx_d;
      win_value_q <= win_value_d;
      iter_q      <= iter_d;
      nz_q        <= nz_d;
      stable_q    <= stable_d;
    end
  end

  // Nonzero count and lowest-index survivor; the sign bit is excluded so -0 is dead.
  always_comb begin
    nz_cnt  = '0;
    found   = 1'b0;
    sel_idx = '0;
    sel_val = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (|x[i*DATA_W +: DATA_W-1]) begin
        nz_cnt = nz_cnt + NZ_W'(1);
        if (!found) begin
          found   = 1'b1;
          sel_idx = IDX_W'(i);
          sel_val = a[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    status_d    = status_q;
    win_idx_d   = win_idx_q;
    win_value_d = win_value_q;
    iter_d      = iter_q;
    nz_d        = nz_q;
    stable_d    = stable_q;
    iter_inc    = iter_q + CNT_W'(1);
    // win_idx_q always holds the previous single survivor whenever stable_q is nonzero.
    stable_nx   = (sel_idx == win_idx_q) ? stable_q + ST_W'(1) : ST_W'(1);

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_RUN;
          status_d    = NONE_YET;
          win_idx_d   = '0;
          win_value_d = '0;
          iter_d      = '0;
          stable_d    = '0;
        end
      end
      ST_RUN: begin
        if (start) begin
          status_d    = NONE_YET;
          win_idx_d   = '0;
          win_value_d = '0;
          iter_d      = '0;
          stable_d    = '0;
        end else if (in_valid) begin
          iter_d = iter_inc;
          nz_d   = nz_cnt;
          if (nz_cnt == '0) begin
            status_d = ALL_ZERO;
            state_d  = ST_DONE;
          end else begin
            if (nz_cnt == NZ_W'(1)) begin
              win_idx_d   = sel_idx;
              win_value_d = sel_val;
              stable_d    = stable_nx;
            end else begin
              stable_d = '0;
            end
            if (nz_cnt == NZ_W'(1) && stable_nx == ST_W'(STABLE)) begin
              status_d = WIN;
              state_d  = ST_DONE;
            end else if (iter_inc == CNT_W'(MAX_ITER)) begin
              status_d = TIMEOUT;
              state_d  = ST_DONE;
            end
          end
        end
      end
      ST_DONE: begin
        if (start) begin
          state_d     = ST_RUN;
          status_d    = NONE_YET;
          win_idx_d   = '0;
          win_value_d = '0;
          iter_d      = '0;
          stable_d    = '0;
        end else if (ack) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign in_ready   = (state_q == ST_RUN);
  assign done       = (state_q == ST_DONE);
  assign status     = status_q;
  assign win_idx    = win_idx_q;
  assign win_value  = win_value_q;
  assign iter_count = iter_q;
  assign nz_count   = nz_q;

endmodule

// File: tb/tb_maxnet_winner_detect.sv
// Directed bench for maxnet_winner_detect: two instances share stimulus,
// one with a long budget and STABLE=1, one with MAX_ITER=4 and STABLE=2.
module tb_maxnet_winner_detect;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         ack;
  logic         in_valid;
  logic [127:0] x;
  logic [127:0] a;

  logic         a_ready, a_done;
  logic [1:0]   a_status;
  logic [1:0]   a_idx;
  logic [31:0]  a_val;
  logic [6:0]   a_iter;
  logic [2:0]   a_nz;

  logic         b_ready, b_done;
  logic [1:0]   b_status;
  logic [1:0]   b_idx;
  logic [31:0]  b_val;
  logic [2:0]   b_iter;
  logic [2:0]   b_nz;

  int total = 0;
  int bad   = 0;

  maxnet_winner_detect #(.N(4), .DATA_W(32), .MAX_ITER(64), .STABLE(1)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start), .ack(ack), .in_valid(in_valid),
    .x(x), .a(a), .in_ready(a_ready), .done(a_done), .status(a_status),
    .win_idx(a_idx), .win_value(a_val), .iter_count(a_iter), .nz_count(a_nz)
  );

  maxnet_winner_detect #(.N(4), .DATA_W(32), .MAX_ITER(4), .STABLE(2)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start), .ack(ack), .in_valid(in_valid),
    .x(x), .a(a), .in_ready(b_ready), .done(b_done), .status(b_status),
    .win_idx(b_idx), .win_value(b_val), .iter_count(b_iter), .nz_count(b_nz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Channel 0 is the first argument.
  function automatic logic [127:0] pk(input logic [31:0] c0, c1, c2, c3);
    return {c3, c2, c1, c0};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [127:0] xv);
    x = xv;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; ack = 1'b0; in_valid = 1'b0;
    x = '0;
    a = pk(32'd10, 32'd20, 32'd30, 32'd40);
    tick(); tick();
    chk("rst_ready",  a_ready,  0);
    chk("rst_done",   a_done,   0);
    chk("rst_status", a_status, 0);
    chk("rst_idx",    a_idx,    0);
    chk("rst_val",    a_val,    0);
    chk("rst_iter",   a_iter,   0);
    chk("rst_nz",     a_nz,     0);
    rst_n = 1'b1;
    tick();
    chk("idle_ready", a_ready, 0);

    // Basic win after three beats
    pulse_start();
    chk("run_ready", a_ready, 1);
    chk("run_iter0", a_iter, 0);
    beat(pk(32'd5, 32'd3, 32'd0, 32'd2));
    chk("w1_done", a_done, 0);
    chk("w1_iter", a_iter, 1);
    chk("w1_nz",   a_nz,   3);
    beat(pk(32'd2, 32'd0, 32'd0, 32'd1));
    chk("w2_done", a_done, 0);
    chk("w2_nz",   a_nz,   2);
    beat(pk(32'd0, 32'd0, 32'd0, 32'h40400000));
    chk("w3_done",   a_done,   1);
    chk("w3_status", a_status, 1);
    chk("w3_idx",    a_idx,    3);
    chk("w3_val",    a_val,    40);
    chk("w3_iter",   a_iter,   3);
    chk("w3_nz",     a_nz,     1);
    chk("w3_ready",  a_ready,  0);
    beat(pk(32'd0, 32'd0, 32'd0, 32'd0));
    chk("done_ign_status", a_status, 1);
    chk("done_ign_iter",   a_iter,   3);
    ack = 1'b1; tick(); ack = 1'b0;
    chk("ack_done",   a_done,   0);
    chk("ack_status", a_status, 1);
    chk("ack_idx",    a_idx,    3);
    chk("ack_val",    a_val,    40);
    chk("ack_ready",  a_ready,  0);

    // Negative zeros count as dead
    pulse_start();
    chk("st_clr_status", a_status, 0);
    chk("st_clr_val",    a_val,    0);
    beat(pk(32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000));
    chk("nz0_done",   a_done,   1);
    chk("nz0_status", a_status, 2);
    chk("nz0_idx",    a_idx,    0);
    chk("nz0_val",    a_val,    0);
    chk("nz0_nz",     a_nz,     0);
    chk("nz0_iter",   a_iter,   1);

    // Timeout on the short-budget instance; sign-bit-plus-LSB channel is live
    pulse_start();
    beat(pk(32'd1, 32'd1, 32'd0, 32'd0));
    beat(pk(32'd0, 32'd7, 32'd0, 32'd9));
    beat(pk(32'd3, 32'd0, 32'h80000001, 32'd0));
    chk("to3_done", b_done, 0);
    chk("to3_iter", b_iter, 3);
    beat(pk(32'd0, 32'd0, 32'd4, 32'd4));
    chk("to4_done",   b_done,   1);
    chk("to4_status", b_status, 3);
    chk("to4_iter",   b_iter,   4);
    chk("to4_nz",     b_nz,     2);
    beat(pk(32'd0, 32'd0, 32'd0, 32'd0));
    chk("to5_iter",   b_iter,   4);
    chk("to5_status", b_status, 3);
    chk("to5_nz",     b_nz,     2);

    // ALL_ZERO wins over TIMEOUT on the last budgeted beat
    pulse_start();
    beat(pk(32'd1, 32'd1, 32'd0, 32'd0));
    beat(pk(32'd1, 32'd1, 32'd0, 32'd0));
    beat(pk(32'd1, 32'd1, 32'd0, 32'd0));
    beat(pk(32'd0, 32'd0, 32'd0, 32'd0));
    chk("pz_status", b_status, 2);
    chk("pz_iter",   b_iter,   4);

    // WIN wins over TIMEOUT on the last budgeted beat
    pulse_start();
    beat(pk(32'd1, 32'd1, 32'd0, 32'd0));
    beat(pk(32'd1, 32'd1, 32'd0, 32'd0));
    beat(pk(32'd0, 32'd6, 32'd0, 32'd0));
    beat(pk(32'd0, 32'd6, 32'd0, 32'd0));
    chk("pw_status", b_status, 1);
    chk("pw_idx",    b_idx,    1);
    chk("pw_iter",   b_iter,   4);

    // STABLE=2: survivor index change restarts the count
    pulse_start();
    beat(pk(32'd0, 32'd5, 32'd0, 32'd0));
    chk("s1_done", b_done, 0);
    chk("s1_idx",  b_idx,  1);
    chk("s1_val",  b_val,  20);
    beat(pk(32'd0, 32'd0, 32'd6, 32'd0));
    chk("s2_done", b_done, 0);
    chk("s2_idx",  b_idx,  2);
    beat(pk(32'd0, 32'd0, 32'd7, 32'd0));
    chk("s3_done",   b_done,   1);
    chk("s3_status", b_status, 1);
    chk("s3_idx",    b_idx,    2);
    chk("s3_val",    b_val,    30);
    chk("s3_iter",   b_iter,   3);

    // Abort mid-run; coincident beat is discarded and stable count restarts
    pulse_start();
    beat(pk(32'd1, 32'd1, 32'd0, 32'd0));
    beat(pk(32'd0, 32'd5, 32'd0, 32'd0));
    chk("ab_pre_iter", b_iter, 2);
    x = pk(32'd0, 32'd5, 32'd0, 32'd0);
    in_valid = 1'b1; start = 1'b1;
    tick();
    in_valid = 1'b0; start = 1'b0;
    chk("ab_iter",   b_iter,   0);
    chk("ab_status", b_status, 0);
    chk("ab_idx",    b_idx,    0);
    chk("ab_ready",  b_ready,  1);
    beat(pk(32'd0, 32'd5, 32'd0, 32'd0));
    chk("ab1_done", b_done, 0);
    chk("ab1_iter", b_iter, 1);
    chk("ab1_idx",  b_idx,  1);
    beat(pk(32'd0, 32'd5, 32'd0, 32'd0));
    chk("ab2_done",   b_done,   1);
    chk("ab2_status", b_status, 1);
    chk("ab2_iter",   b_iter,   2);

    // start and ack together in DONE restarts the run
    start = 1'b1; ack = 1'b1;
    tick();
    start = 1'b0; ack = 1'b0;
    chk("sa_ready",  b_ready,  1);
    chk("sa_done",   b_done,   0);
    chk("sa_status", b_status, 0);
    chk("sa_iter",   b_iter,   0);

    // Asynchronous reset between clock edges
    beat(pk(32'd0, 32'd5, 32'd0, 32'd0));
    chk("ar_pre_val", b_val, 20);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_ready", b_ready, 0);
    chk("ar_done",  b_done,  0);
    chk("ar_idx",   b_idx,   0);
    chk("ar_val",   b_val,   0);
    chk("ar_iter",  b_iter,  0);
    chk("ar_nz",    b_nz,    0);
    chk("ar_a_nz",  a_nz,    0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("ar_idle", b_ready, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
